lutram_fwft_fifo: RTL and testbench

Synchronous 128-deep first-word-fall-through FIFO built on dual-port LUT RAM. The write side drives the RAM write port (`A`/`D`/`WE`). The read side consumes the asynchronous `DPO` port through a prefetch register, so `RD_DATA` comes from a flop. It is the standard buffering stage placed behind distributed-RAM primitives, used wherever a 1-clock stream needs elastic storage without block RAM.

---
 rtl/lutram_fifo_pkg.sv | 9 +
 rtl/ram128xw_dp.sv | 48 ++++
 rtl/lutram_fwft_fifo.sv | 98 +++++++++
 tb/tb_lutram_fwft_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lutram_fifo_pkg.sv
// Shared sizing for the 128-deep LUT-RAM first-word-fall-through FIFO.
package lutram_fifo_pkg;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int CW    = 8;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
endpackage

// File: rtl/ram128xw_dp.sv
// WIDTH-wide 128-deep dual-port distributed RAM assembled from 128x1 columns.
// Includes a behavioural RAM128X1D so the slice simulates without vendor libraries.
module RAM128X1D (
  output logic       DPO,
  output logic       SPO,
  input  logic       D,
  input  logic       WCLK,
  input  logic       WE,
  input  logic [6:0] A,
  input  logic [6:0] DPRA
);
  logic [127:0] mem_q;

  always_ff @(posedge WCLK) begin
    if (WE) mem_q[A] <= D;
  end

  assign SPO = mem_q[A];
  assign DPO = mem_q[DPRA];
endmodule

module ram128xw_dp
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             wclk,
  input  logic             we,
  input  ptr_t             a,
  input  ptr_t             dpra,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] dpo
);
  // Single-port read side is never used; the name keeps it out of unused-signal reports.
  logic [WIDTH-1:0] spo_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    RAM128X1D u_col (
      .DPO  (dpo[i]),
      .SPO  (spo_unused[i]),
      .D    (d[i]),
      .WCLK (wclk),
      .WE   (we),
      .A    (a),
      .DPRA (dpra)
    );
  end
endmodule

// File: rtl/lutram_fwft_fifo.sv
// 128-deep first-word-fall-through FIFO: LUT RAM storage plus a registered
// prefetch stage so RD_DATA always comes from a flop.
module lutram_fwft_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             FULL,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             EMPTY,
  output logic [7:0]       COUNT,
  output logic             OVF,
  output logic             UDF
);
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             ram_cnt_q, ram_cnt_d;
  logic             dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             wr_acc, rd_acc, prefetch;
  cnt_t             count_d;
  logic [WIDTH-1:0] dpo;

  ram128xw_dp #(.WIDTH(WIDTH)) u_ram (
    .wclk (CLK),
    .we   (wr_acc),
    .a    (wr_ptr_q),
    .dpra (rd_ptr_q),
    .d    (WR_DATA),
    .dpo  (dpo)
  );

  always_comb begin
    wr_acc       = WR_EN & ~full_q;
    rd_acc       = RD_EN & ~empty_q;
    // A freed (or never-filled) output slot is refilled from RAM on the same edge.
    prefetch     = (~dout_valid_q | rd_acc) & (ram_cnt_q != '0);

    wr_ptr_d     = wr_ptr_q + ptr_t'(wr_acc);
    rd_ptr_d     = rd_ptr_q + ptr_t'(prefetch);
    ram_cnt_d    = ram_cnt_q + cnt_t'(wr_acc) - cnt_t'(prefetch);
    dout_valid_d = dout_valid_q;
    rd_data_d    = rd_data_q;
    if (prefetch) begin
      dout_valid_d = 1'b1;
      rd_data_d    = dpo;
    end else if (rd_acc) begin
      dout_valid_d = 1'b0;
    end

    count_d = ram_cnt_d + cnt_t'(dout_valid_d);
    full_d  = (count_d == cnt_t'(DEPTH));
    empty_d = ~dout_valid_d;
    ovf_d   = WR_EN & full_q;
    udf_d   = RD_EN & empty_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      dout_valid_q <= 1'b0;
      rd_data_q    <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      dout_valid_q <= dout_valid_d;
      rd_data_q    <= rd_data_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  assign FULL    = full_q;
  assign EMPTY   = empty_q;
  assign RD_DATA = rd_data_q;
  assign COUNT   = ram_cnt_q + cnt_t'(dout_valid_q);
  assign OVF     = ovf_q;
  assign UDF     = udf_q;
endmodule

// File: tb/tb_lutram_fwft_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_lutram_fwft_fifo;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             WR_EN = 1'b0;
  logic [WIDTH-1:0] WR_DATA = '0;
  logic             RD_EN = 1'b0;
  logic             FULL, EMPTY, OVF, UDF;
  logic [WIDTH-1:0] RD_DATA;
  logic [7:0]       COUNT;

  lutram_fwft_fifo #(.WIDTH(WIDTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .FULL    (FULL),
    .RD_EN   (RD_EN),
    .RD_DATA (RD_DATA),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT),
    .OVF     (OVF),
    .UDF     (UDF)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is a queue of words; the head is visible only
  // once it was already stored before the edge that exposes it.
  logic [WIDTH-1:0] q[$];
  bit               m_vis  = 0;
  logic [WIDTH-1:0] m_last = '0;
  bit               m_ovf  = 0;
  bit               m_udf  = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_vis  = 0;
      m_last = '0;
      m_ovf  = 0;
      m_udf  = 0;
    end else begin
      bit full_pre, empty_pre, wacc, racc;
      int older;
      full_pre  = (q.size() == 128);
      empty_pre = !m_vis;
      wacc      = WR_EN && !full_pre;
      racc      = RD_EN && !empty_pre;
      older     = q.size();
      if (racc) begin
        void'(q.pop_front());
        older--;
      end
      m_vis = (older > 0);
      if (wacc) q.push_back(WR_DATA);
      if (m_vis) m_last = q[0];
      m_ovf = WR_EN && full_pre;
      m_udf = RD_EN && empty_pre;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("model_empty", int'(EMPTY), int'(!m_vis));
      chk("model_full",  int'(FULL),  int'(q.size() == 128));
      chk("model_count", int'(COUNT), q.size());
      chk("model_data",  int'(RD_DATA), int'(m_last));
      chk("model_ovf",   int'(OVF),   int'(m_ovf));
      chk("model_udf",   int'(UDF),   int'(m_udf));
    end
  end

  // Drive inputs for one cycle, return just after the following falling edge.
  task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r);
    WR_EN   = w;
    WR_DATA = d;
    RD_EN   = r;
    @(negedge CLK);
    WR_EN = 1'b0;
    RD_EN = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] prev;
    // Reset
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_full", int'(FULL), 0);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_data", int'(RD_DATA), 0);
    chk("rst_ovf", int'(OVF), 0);
    chk("rst_udf", int'(UDF), 0);

    // Single word
    cyc(1, 8'hA5, 0);
    chk("single_count_t", int'(COUNT), 1);
    chk("single_empty_t", int'(EMPTY), 1);
    cyc(0, 8'h00, 0);
    chk("single_empty_t1", int'(EMPTY), 0);
    chk("single_data", int'(RD_DATA), 8'hA5);
    cyc(0, 8'h00, 1);
    chk("single_empty_after_rd", int'(EMPTY), 1);
    chk("single_count_after_rd", int'(COUNT), 0);

    // Fill and overflow
    for (int i = 0; i < 128; i++) cyc(1, 8'(i), 0);
    chk("fill_full", int'(FULL), 1);
    chk("fill_count", int'(COUNT), 128);
    cyc(1, 8'hFF, 0);
    chk("ovf_pulse", int'(OVF), 1);
    chk("ovf_count", int'(COUNT), 128);
    cyc(0, 8'h00, 0);
    chk("ovf_clear", int'(OVF), 0);
    chk("head_first", int'(RD_DATA), 8'h00);
    // Read and write together at full: write dropped
    cyc(1, 8'hEE, 1);
    chk("full_rw_ovf", int'(OVF), 1);
    chk("full_rw_count", int'(COUNT), 127);
    chk("full_rw_full", int'(FULL), 0);
    for (int i = 1; i < 128; i++) begin
      chk("drain_order", int'(RD_DATA), i);
      cyc(0, 8'h00, 1);
    end
    chk("drain_empty", int'(EMPTY), 1);
    chk("drain_count", int'(COUNT), 0);

    // Steady stream at COUNT=5 across pointer wraps
    for (int i = 0; i < 5; i++) cyc(1, 8'(i), 0);
    cyc(0, 8'h00, 0);
    chk("stream_pre_count", int'(COUNT), 5);
    prev = RD_DATA;
    chk("stream_head", int'(prev), 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 8'(i + 5), 1);
      chk("stream_count", int'(COUNT), 5);
      chk("stream_seq", int'(RD_DATA), int'(8'(prev + 8'd1)));
      prev = RD_DATA;
    end
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);
    chk("stream_drained", int'(EMPTY), 1);

    // Underflow
    cyc(0, 8'h00, 1);
    chk("udf_pulse", int'(UDF), 1);
    chk("udf_count", int'(COUNT), 0);
    cyc(0, 8'h00, 0);
    chk("udf_clear", int'(UDF), 0);

    // Randomized traffic, write-biased then read-biased
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = (i < 1500) ? 70 : 30;
      cyc($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < (100 - wp));
    end

    // Reset mid-operation at COUNT=40
    for (int i = 0; i < 200; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < 40; i++) cyc(1, 8'(8'h80 + i), 0);
    chk("pre_rst_count", int'(COUNT), 40);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_empty", int'(EMPTY), 1);
    chk("async_rst_count", int'(COUNT), 0);
    @(negedge CLK);
    RST = 1'b0;
    cyc(1, 8'h3C, 0);
    cyc(0, 8'h00, 0);
    chk("post_rst_data", int'(RD_DATA), 8'h3C);
    chk("post_rst_empty", int'(EMPTY), 0);
    cyc(0, 8'h00, 1);
    chk("post_rst_drained", int'(COUNT), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
